// File: rtl/add_tree_sequencer.sv
// Sequential adder tree: loads N unsigned operands, then folds them pairwise
// through a single shared adder in N-1 cycles and presents the batch sum.
module add_tree_sequencer #(
    parameter int IN_W  = 6,
    parameter int LOG2N = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [IN_W+LOG2N-1:0]   out_sum,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int N     = 1 << LOG2N;
    localparam int OUT_W = IN_W + LOG2N;
    localparam int LVL_W = $clog2(LOG2N + 1);

    typedef enum logic [1:0] {
        LOAD,
        REDUCE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] load_cnt_q, load_cnt_d;
    logic [LOG2N-1:0] pair_q, pair_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic [OUT_W-1:0] slot_q [N];

    logic [LOG2N-1:0] rd_a, rd_b;
    logic [OUT_W-1:0] add_sum;
    logic [LOG2N:0]   pairs_in_level;
    logic             last_pair, last_level;
    logic             load_we, red_we;

    // Add j of a level reads slots 2j and 2j+1 and writes slot j; writes
    // always land below the read window, so in-place folding is safe.
    assign rd_a           = pair_q << 1;
    assign rd_b           = rd_a | LOG2N'(1);
    assign add_sum        = slot_q[rd_a] + slot_q[rd_b];
    assign pairs_in_level = (LOG2N+1)'(N) >> (level_q + LVL_W'(1));
    assign last_pair      = ({1'b0, pair_q} == pairs_in_level - (LOG2N+1)'(1));
    assign last_level     = (level_q == LVL_W'(LOG2N - 1));

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        pair_d     = pair_q;
        level_d    = level_q;
        in_ready   = (state_q == LOAD);
        out_valid  = (state_q == DONE);
        busy       = (state_q != LOAD);
        out_sum    = (state_q == DONE) ? slot_q[0] : '0;
        load_we    = 1'b0;
        red_we     = 1'b0;

        if (abort) begin
            state_d    = LOAD;
            load_cnt_d = '0;
            pair_d     = '0;
            level_d    = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        load_we    = 1'b1;
                        load_cnt_d = load_cnt_q + LOG2N'(1);
                        if (load_cnt_q == LOG2N'(N - 1)) begin
                            state_d = REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    red_we = 1'b1;
                    if (last_pair) begin
                        pair_d = '0;
                        if (last_level) begin
                            level_d = '0;
                            state_d = DONE;
                        end else begin
                            level_d = level_q + LVL_W'(1);
                        end
                    end else begin
                        pair_d = pair_q + LOG2N'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = LOAD;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            pair_q     <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            pair_q     <= pair_d;
            level_q    <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_we) begin
            slot_q[load_cnt_q] <= OUT_W'(in_data);
        end else if (red_we) begin
            slot_q[pair_q] <= add_sum;
        end
    end

endmodule

// File: tb/tb_add_tree_sequencer.sv
// Directed bench for add_tree_sequencer: a batch-level model (running sum plus
// fixed N-1 cycle latency) is compared against the DUT every cycle.
module tb_add_tree_sequencer;

    localparam int IN_W  = 6;
    localparam int LOG2N = 5;
    localparam int N     = 1 << LOG2N;
    localparam int OUT_W = IN_W + LOG2N;

    logic             clk;
    logic             rst_n;
    logic             abort;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_sum;
    logic             out_ready;
    logic             busy;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: phase 0 = accepting, 1 = summing, 2 = result shown.
    int m_phase = 0;
    int m_cnt   = 0;
    int m_acc   = 0;
    int m_wait  = 0;
    int m_sum   = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    int   rise_cyc = 0;
    int   n_rises  = 0;
    logic prev_ov  = 1'b0;
    logic [OUT_W-1:0] got[$];

    add_tree_sequencer #(.IN_W(IN_W), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_acc   <= 0;
            m_wait  <= 0;
        end else begin
            cyc <= cyc + 1;
            if (abort) begin
                m_phase <= 0;
                m_cnt   <= 0;
                m_acc   <= 0;
            end else begin
                case (m_phase)
                    0: if (in_valid) begin
                        if (m_cnt == N - 1) begin
                            m_phase <= 1;
                            m_wait  <= N - 1;
                            m_sum   <= m_acc + int'(in_data);
                            m_cnt   <= 0;
                            m_acc   <= 0;
                            acc_cyc <= cyc + 1;
                        end else begin
                            m_cnt <= m_cnt + 1;
                            m_acc <= m_acc + int'(in_data);
                        end
                    end
                    1: begin
                        if (m_wait == 1) m_phase <= 2;
                        m_wait <= m_wait - 1;
                    end
                    2: if (out_ready) m_phase <= 0;
                    default: m_phase <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready",  32'(in_ready),  32'(m_phase == 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("busy",      32'(busy),      32'(m_phase != 0));
            if (m_phase == 2) chk("out_sum", 32'(out_sum), m_sum);
            if (out_valid && !prev_ov) begin
                rise_cyc <= cyc;
                n_rises  <= n_rises + 1;
            end
            if (out_valid && out_ready) got.push_back(out_sum);
        end
        prev_ov <= out_valid;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = v[IN_W-1:0];
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_batch(input int v);
        for (int i = 0; i < N; i++) send(v);
    endtask

    task automatic wait_hs(input int nexp, input string name);
        int k = 0;
        while (got.size() < nexp && k < 200) begin
            step();
            k++;
        end
        if (got.size() < nexp) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: handshake count %0d expected %0d", name, got.size(), nexp);
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 100) begin
            step();
            k++;
        end
        if (!out_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: out_valid got 0 expected 1 within budget", name);
        end
    endtask

    initial begin
        int r0;
        logic [OUT_W-1:0] s0;
        rst_n     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_out_sum",   32'(out_sum),   0);
        step();
        rst_n = 1'b1;

        // All-max batch, consumer always ready
        out_ready = 1'b1;
        send_batch(63);
        wait_hs(1, "hs_all63");
        chk("sum_all63", 32'(got[0]), 2016);
        chk("latency",   rise_cyc - acc_cyc, 31);
        chk("ready_after_done", 32'(in_ready), 1);

        // Ramp with gaps; junk offered during reduction
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            int g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) step();
            send(i);
        end
        in_valid  = 1'b1;
        in_data   = 6'd63;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && !out_valid; k++) step();
        in_valid = 1'b0;
        wait_hs(2, "hs_ramp");
        chk("sum_ramp", 32'(got[1]), 496);

        // Backpressure for 10 cycles, then one handshake
        out_ready = 1'b0;
        send_batch(5);
        wait_valid("valid_hold");
        s0 = out_sum;
        chk("hold_first", 32'(s0), 160);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_sum",   32'(out_sum),   32'(s0));
            if (i < 9) step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_hs",    got.size(), 3);
        chk("valid_dropped", 32'(out_valid), 0);
        out_ready = 1'b1;
        send_batch(1);
        wait_hs(4, "hs_ones");
        chk("sum_ones", 32'(got[3]), 32);

        // Abort mid-load, coinciding with an offered operand
        for (int i = 0; i < 17; i++) send(7);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'd50;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_load_ready", 32'(in_ready), 1);
        send_batch(2);
        wait_hs(5, "hs_twos");
        chk("sum_twos", 32'(got[4]), 64);

        // Abort on the 10th reduction cycle
        send_batch(9);
        for (int i = 0; i < 9; i++) step();
        r0 = n_rises;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_red_ready", 32'(in_ready), 1);
        chk("abort_red_busy",  32'(busy),     0);
        for (int i = 0; i < 50; i++) step();
        chk("abort_no_rise", n_rises, r0);
        chk("abort_no_hs",   got.size(), 5);

        // Asynchronous reset while the result is shown
        out_ready = 1'b0;
        send_batch(4);
        wait_valid("valid_pre_rst");
        chk("sum_fours", 32'(out_sum), 128);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready",  32'(in_ready),  1);
        chk("arst_busy",      32'(busy),      0);
        chk("arst_out_sum",   32'(out_sum),   0);
        step();
        rst_n = 1'b1;
        r0 = n_rises;
        out_ready = 1'b1;
        send_batch(0);
        wait_hs(6, "hs_zeros");
        chk("sum_zeros",  32'(got[5]), 0);
        chk("rise_count", n_rises - r0, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/add_tree_sequencer.md
ADD_TREE_SEQUENCER -- requirements
Module: add_tree_sequencer

Interface
REQ-001 SHALL have parameter IN_W, default 6, meaning the width of each unsigned operand.
REQ-002 SHALL have parameter LOG2N, default 5, meaning log2 of the operand count, so N = 32 operands by default.
REQ-003 SHALL have derived width OUT_W = IN_W + LOG2N (11 by default).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port abort, input, 1 bit: synchronous discard of the current batch.
REQ-007 SHALL have port in_valid, input, 1 bit: operand offered.
REQ-008 SHALL have port in_data, input, IN_W bits: unsigned operand.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts an operand this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: the batch sum is available.
REQ-011 SHALL have port out_sum, output, OUT_W bits: sum of the N accepted operands.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes out_sum.
REQ-013 SHALL have port busy, output, 1 bit: high in REDUCE or DONE.

Function
REQ-014 SHALL implement states LOAD, REDUCE and DONE, using exactly one shared 2-input adder of width OUT_W for all reduction.
REQ-015 LOAD: in_ready=1; each cycle with in_valid&in_ready SHALL zero-extend in_data and write it to operand slot load_cnt, then increment load_cnt.
REQ-016 LOAD SHALL go to REDUCE on the edge that accepts operand N-1; load_cnt SHALL wrap to 0 at that edge.
REQ-017 REDUCE: in_ready=0; the sequencer SHALL run LOG2N levels; level L (0-based) SHALL perform N>>(L+1) adds, one per cycle.
REQ-018 Add j of level L SHALL write slot[2j] + slot[2j+1] into slot[j]; addresses SHALL be computed from counters, not stored.
REQ-019 Total REDUCE duration SHALL be N-1 cycles (31 by default); after the last add, the state SHALL go to DONE.
REQ-020 DONE: out_valid=1 and out_sum=slot[0]; out_sum SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1, the block SHALL go to LOAD on that edge; in_ready SHALL be 1 in the next cycle.
REQ-022 Latency: out_valid SHALL rise exactly N-1 cycles after the edge that accepted the Nth operand.
REQ-023 Arithmetic SHALL be unsigned and overflow-free, since N*(2^IN_W-1) < 2^OUT_W (2016 < 2048 by default).
REQ-024 in_valid SHALL be ignored outside LOAD, and out_ready SHALL be ignored outside DONE.
REQ-025 abort=1 SHALL take priority over all other inputs in any state: next state LOAD, load_cnt=0, reduction counters=0, out_valid=0; stored operands need not be cleared.
REQ-026 abort asserted in the same cycle as an accepted operand SHALL discard that operand.
REQ-027 A partially loaded batch SHALL be held indefinitely while in_valid=0.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=LOAD, load_cnt=0, level and pair counters=0, in_ready=1, out_valid=0, busy=0, out_sum=0.
REQ-029 Operand storage need not be reset.
REQ-030 Deassertion of rst_n SHALL be synchronised externally; the first accept SHALL occur on the first rising edge with rst_n=1 and in_valid=1.
REQ-031 Reset asserted mid-REDUCE or in DONE SHALL discard the batch; no out_valid pulse SHALL appear afterwards.

Verification
REQ-032 Stimulus: 32 back-to-back operands all 63, out_ready=1. Response: out_sum=2016 with out_valid exactly 31 cycles after the last accept, then in_ready=1 on the following cycle.
REQ-033 Stimulus: operands 0..31 with random in_valid gaps. Response: out_sum=496; in_ready=0 throughout REDUCE; inputs offered during REDUCE change nothing.
REQ-034 Stimulus: batch completes with out_ready held 0 for 10 cycles. Response: out_valid and out_sum stable for those 10 cycles; a single handshake on release; the next batch of all 1s gives 32.
REQ-035 Stimulus: abort after 17 loaded operands, then 32 operands of value 2. Response: out_sum=64.
REQ-036 Stimulus: abort at REDUCE cycle 10. Response: no out_valid, in_ready=1 on the next cycle.
REQ-037 Stimulus: rst_n pulsed low asynchronously in DONE. Response: out_valid=0 immediately; the next full batch of all 0s gives out_sum=0.
